reg_file: RTL

- Parametrised multi-port register file for the VeriRISC datapath; next generation of the single enable-gated register.
- DEPTH entries of WIDTH bits, one write port with per-lane write mask, RD_PORTS independent registered read ports.
- Optional write-to-read bypass and an optional hard-wired zero entry.
- Sits between instruction decode and the ALU/accumulator; replaces banks of discrete enabled registers.

---
 rtl/reg_file_pkg.sv | 31 +++
 rtl/reg_file_rd_port.sv | 63 ++++++
 rtl/reg_file.sv | 67 ++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared sizing helpers, lane-mask type and the lane merge used by the register file
// write path and by every read-port bypass.
package reg_file_pkg;

  localparam int MAX_W = 256;

  typedef logic [MAX_W-1:0] word_t;
  typedef logic [MAX_W-1:0] lane_mask_t;

  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int calc_lanes(input int width, input int lane_w);
    return width / lane_w;
  endfunction

  // Bit i comes from new_w when its lane (i / lane_w) is enabled, otherwise from old_w.
  function automatic word_t merge_lanes(input word_t old_w, input word_t new_w,
                                        input lane_mask_t mask, input int lane_w);
    word_t res;
    logic [7:0] lane;
    res = old_w;
    for (int i = 0; i < MAX_W; i++) begin
      lane = 8'(i / lane_w);
      if (mask[lane]) res[i[7:0]] = new_w[i[7:0]];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: entry select, same-cycle write bypass, zero-entry forcing
// and the rdata/rvalid output flops.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LANE_W   = 4,
  parameter int DEPTH    = 8,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int AW      = calc_aw(DEPTH),
  localparam int LANES   = calc_lanes(WIDTH, LANE_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic [AW-1:0]          raddr,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [LANES-1:0]       wmask,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [DEPTH*WIDTH-1:0] mem_flat,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rvalid
);

  logic [WIDTH-1:0] ent [DEPTH];
  logic [WIDTH-1:0] old_p0;
  logic [WIDTH-1:0] next_p0;
  logic             hit_p0;
  logic [WIDTH-1:0] rdata_p1;
  logic             vld_p1;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent[i] = mem_flat[i*WIDTH +: WIDTH];
  end

  // Stage p0: select entry, merge an in-flight write to the same address, force entry 0
  always_comb begin
    old_p0  = ent[raddr];
    hit_p0  = (BYPASS != 0) && we && (waddr == raddr);
    next_p0 = old_p0;
    if (hit_p0)
      next_p0 = WIDTH'(merge_lanes(word_t'(old_p0), word_t'(wdata), lane_mask_t'(wmask), LANE_W));
    if ((ZERO_REG != 0) && (raddr == '0))
      next_p0 = '0;
  end

  // Stage p1: registered outputs; data holds while no read is requested
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) rdata_p1 <= next_p0;
    end
  end

  assign rdata  = rdata_p1;
  assign rvalid = vld_p1;

endmodule

// File: rtl/reg_file.sv
// Multi-port register file: DEPTH x WIDTH storage with a lane-masked write port and
// RD_PORTS independent one-cycle read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LANE_W   = 4,
  parameter int DEPTH    = 8,
  parameter int RD_PORTS = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int AW      = calc_aw(DEPTH),
  localparam int LANES   = calc_lanes(WIDTH, LANE_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [LANES-1:0]          wmask,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [RD_PORTS-1:0]       rd_en,
  input  logic [RD_PORTS*AW-1:0]    raddr,
  output logic [RD_PORTS*WIDTH-1:0] rdata,
  output logic [RD_PORTS-1:0]       rvalid
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH*WIDTH-1:0]      mem_flat;
  logic [WIDTH-1:0]            wr_merged;
  logic                        wr_ok;

  assign mem_flat  = mem;
  assign wr_merged = WIDTH'(merge_lanes(word_t'(mem[waddr]), word_t'(wdata),
                                        lane_mask_t'(wmask), LANE_W));
  assign wr_ok     = we && !((ZERO_REG != 0) && (waddr == '0));

  // Reset clears the whole array and wins over a concurrent write
  always_ff @(posedge clk) begin
    if (reset)
      mem <= '0;
    else if (wr_ok)
      mem[waddr] <= wr_merged;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    reg_file_rd_port #(
      .WIDTH   (WIDTH),
      .LANE_W  (LANE_W),
      .DEPTH   (DEPTH),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en[p]),
      .raddr   (raddr[p*AW +: AW]),
      .we      (we),
      .waddr   (waddr),
      .wmask   (wmask),
      .wdata   (wdata),
      .mem_flat(mem_flat),
      .rdata   (rdata[p*WIDTH +: WIDTH]),
      .rvalid  (rvalid[p])
    );
  end

endmodule
